// File: rtl/vec_mem_bridge_if.sv
// rtl/vec_mem_bridge_if.sv - coprocessor-side and memory-side signals of the vector memory bridge
interface vec_mem_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              is_vstype;
  logic [ADDR_W-1:0] v_data_addr;
  logic [DATA_W-1:0] v_store_data_0, v_store_data_1, v_store_data_2, v_store_data_3;
  logic [DATA_W-1:0] v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3;
  logic              done;
  logic              busy;
  logic              mem_req;
  logic              mem_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, is_vstype, v_data_addr,
    input  v_store_data_0, v_store_data_1, v_store_data_2, v_store_data_3,
    input  mem_grant, mem_rdata,
    output req_ready, done, busy,
    output v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3,
    output mem_req, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, is_vstype, v_data_addr,
    output v_store_data_0, v_store_data_1, v_store_data_2, v_store_data_3,
    output mem_grant, mem_rdata,
    input  req_ready, done, busy,
    input  v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3,
    input  mem_req, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vec_mem_bridge.sv
// rtl/vec_mem_bridge.sv - serialises a 4-lane vector load/store into granted single-word memory beats
module vec_mem_bridge #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LANES  = 4
) (
  input logic             clk,
  input logic             rst,
  vec_mem_bridge_if.slave bus
);
  localparam int KW = $clog2(LANES);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, LDRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base;
  logic [KW-1:0]     k;
  logic [KW-1:0]     pend_lane;
  logic              pend;
  logic [DATA_W-1:0] st_lane [LANES];
  logic [DATA_W-1:0] ld_lane [LANES];
  logic              accept;
  logic              beat;
  logic              last;
  logic [ADDR_W-1:0] addr_k;

  assign addr_k = base + ADDR_W'(k);
  assign last   = (k == KW'(LANES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // mem_we is gated by the grant here so a stalled store beat never writes
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    beat          = 1'b0;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = bus.is_vstype ? STORE : LOAD;
        end
      end
      STORE: begin
        bus.mem_req   = 1'b1;
        bus.mem_addr  = addr_k;
        bus.mem_wdata = st_lane[k];
        if (bus.mem_grant) begin
          bus.mem_we = 4'hF;
          beat       = 1'b1;
          if (last) state_next = DONE;
        end
      end
      LOAD: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_k;
        if (bus.mem_grant) begin
          beat = 1'b1;
          if (last) state_next = LDRAIN;
        end
      end
      LDRAIN:  state_next = DONE;
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data returns one cycle after its granted beat, so the lane index rides along in pend_lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= '0;
      k         <= '0;
      pend      <= 1'b0;
      pend_lane <= '0;
      for (int i = 0; i < LANES; i++) begin
        st_lane[i] <= '0;
        ld_lane[i] <= '0;
      end
    end else begin
      pend <= beat && (state == LOAD);
      if (accept) begin
        base       <= bus.v_data_addr;
        k          <= '0;
        st_lane[0] <= bus.v_store_data_0;
        st_lane[1] <= bus.v_store_data_1;
        st_lane[2] <= bus.v_store_data_2;
        st_lane[3] <= bus.v_store_data_3;
      end else if (beat) begin
        k <= k + 1'b1;
        if (state == LOAD) pend_lane <= k;
      end
      if (pend) ld_lane[pend_lane] <= bus.mem_rdata;
    end
  end

  assign bus.v_load_data_0 = ld_lane[0];
  assign bus.v_load_data_1 = ld_lane[1];
  assign bus.v_load_data_2 = ld_lane[2];
  assign bus.v_load_data_3 = ld_lane[3];
endmodule
